// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (align, add, normalize/round); 3-cycle latency, 1/cycle,
// each stage advances when its successor is empty or advancing. Define FP_ADD_FLAGS_EN to add the {invalid, overflow, inexact} flags port.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     float1,
  input  logic [EXP_W+MAN_W:0]     float2,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result
`ifdef FP_ADD_FLAGS_EN
  ,
  output logic [2:0]               flags
`endif
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int XW  = MAN_W + 4;
  localparam int LZW = $clog2(XW + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  // Stage control
  logic s1_v_q, s2_v_q, s3_v_q;
  logic s2_adv, s3_adv;

  assign s3_adv    = !s3_v_q || out_ready;
  assign s2_adv    = !s2_v_q || s3_adv;
  assign in_ready  = !s1_v_q || s2_adv;
  assign out_valid = s3_v_q;

  // S1: unpack, order by magnitude, align the smaller operand
  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
  logic [EXP_W-1:0] ea, eb, el, es, exp_diff;
  logic [MAN_W-1:0] fa, fb;
  logic [W-2:0]     mag_a, mag_b, mag_l, mag_s;
  logic [MAN_W:0]   ml, ms;
  logic [2*MAN_W+5:0] sh_w;
  logic [XW-1:0]    lx_d, sx_d;
  logic             s1_sign_d, s1_sub_d, s1_nan_d, s1_inf_d, s1_inf_sign_d, s1_nz_d;

  assign sa = float1[W-1];
  assign sb = float2[W-1] ^ sub;
  assign ea = float1[W-2 -: EXP_W];
  assign eb = float2[W-2 -: EXP_W];
  assign fa = float1[MAN_W-1:0];
  assign fb = float2[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_MAX) && (fa == '0);
  assign b_inf  = (eb == EXP_MAX) && (fb == '0);
  assign a_nan  = (ea == EXP_MAX) && (fa != '0);
  assign b_nan  = (eb == EXP_MAX) && (fb != '0);

  always_comb begin
    mag_a    = a_zero ? '0 : float1[W-2:0];
    mag_b    = b_zero ? '0 : float2[W-2:0];
    a_big    = (mag_a >= mag_b);
    mag_l    = a_big ? mag_a : mag_b;
    mag_s    = a_big ? mag_b : mag_a;
    el       = mag_l[W-2:MAN_W];
    es       = mag_s[W-2:MAN_W];
    ml       = {|el, mag_l[MAN_W-1:0]};
    ms       = {|es, mag_s[MAN_W-1:0]};
    exp_diff = el - es;
    sh_w     = {ms, 2'b00, {(MAN_W+3){1'b0}}} >> exp_diff;
    // Beyond the round bit the smaller operand only matters as sticky
    if (int'(exp_diff) >= MAN_W + 3)
      sx_d = {{(XW-1){1'b0}}, |ms};
    else
      sx_d = {sh_w[2*MAN_W+5:MAN_W+3], |sh_w[MAN_W+2:0]};
    lx_d          = {ml, 3'b000};
    s1_sign_d     = a_big ? sa : sb;
    s1_sub_d      = sa ^ sb;
    s1_nan_d      = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
    s1_inf_d      = a_inf || b_inf;
    s1_inf_sign_d = a_inf ? sa : sb;
    s1_nz_d       = a_zero && b_zero && sa && sb;
  end

  logic             s1_sign_q, s1_sub_q, s1_nan_q, s1_inf_q, s1_inf_sign_q, s1_nz_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [XW-1:0]    s1_lx_q, s1_sx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q        <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_nan_q      <= 1'b0;
      s1_inf_q      <= 1'b0;
      s1_inf_sign_q <= 1'b0;
      s1_nz_q       <= 1'b0;
      s1_exp_q      <= '0;
      s1_lx_q       <= '0;
      s1_sx_q       <= '0;
    end else if (in_ready) begin
      s1_v_q        <= in_valid;
      s1_sign_q     <= s1_sign_d;
      s1_sub_q      <= s1_sub_d;
      s1_nan_q      <= s1_nan_d;
      s1_inf_q      <= s1_inf_d;
      s1_inf_sign_q <= s1_inf_sign_d;
      s1_nz_q       <= s1_nz_d;
      s1_exp_q      <= el;
      s1_lx_q       <= lx_d;
      s1_sx_q       <= sx_d;
    end
  end

  // S2: magnitude add/sub; larger operand first so the difference is never negative
  logic [XW:0] s2_sum_d;

  assign s2_sum_d = s1_sub_q ? ({1'b0, s1_lx_q} - {1'b0, s1_sx_q})
                             : ({1'b0, s1_lx_q} + {1'b0, s1_sx_q});

  logic             s2_sign_q, s2_nan_q, s2_inf_q, s2_inf_sign_q, s2_nz_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [XW:0]      s2_sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q        <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_nan_q      <= 1'b0;
      s2_inf_q      <= 1'b0;
      s2_inf_sign_q <= 1'b0;
      s2_nz_q       <= 1'b0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
    end else if (s2_adv) begin
      s2_v_q        <= s1_v_q;
      s2_sign_q     <= s1_sign_q;
      s2_nan_q      <= s1_nan_q;
      s2_inf_q      <= s1_inf_q;
      s2_inf_sign_q <= s1_inf_sign_q;
      s2_nz_q       <= s1_nz_q;
      s2_exp_q      <= s1_exp_q;
      s2_sum_q      <= s2_sum_d;
    end
  end

  // S3: normalize, round to nearest even, pack
  function automatic logic [LZW-1:0] lzc(input logic [XW-1:0] x);
    logic [LZW-1:0] n;
    n = LZW'(XW);
    for (int i = 0; i < XW; i++)
      if (x[i]) n = LZW'(XW - 1 - i);
    return n;
  endfunction

  logic [LZW-1:0]   lz;
  logic [XW-1:0]    norm;
  logic [EXP_W+1:0] exp_n, exp_f;
  logic             rnd_up, sum_zero, tiny, ovf;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac_r;
  logic [W-1:0]     res_d;

  always_comb begin
    lz = lzc(s2_sum_q[XW-1:0]);
    if (s2_sum_q[XW]) begin
      norm  = {s2_sum_q[XW:2], |s2_sum_q[1:0]};
      exp_n = {2'b00, s2_exp_q} + (EXP_W+2)'(1);
    end else begin
      norm  = s2_sum_q[XW-1:0] << lz;
      exp_n = {2'b00, s2_exp_q} - (EXP_W+2)'(lz);
    end
    rnd_up   = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant_r   = {1'b0, norm[XW-1:3]} + (MAN_W+2)'(rnd_up);
    exp_f    = exp_n + (EXP_W+2)'(mant_r[MAN_W+1]);
    frac_r   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    sum_zero = (s2_sum_q == '0);
    // Negative exponent shows up as a wrapped top bit
    tiny     = exp_n[EXP_W+1] || (exp_n == '0);
    ovf      = (exp_f >= {2'b00, EXP_MAX});

    res_d = {s2_sign_q, exp_f[EXP_W-1:0], frac_r};
    if (s2_nan_q)
      res_d = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
    else if (s2_inf_q)
      res_d = {s2_inf_sign_q, EXP_MAX, {MAN_W{1'b0}}};
    else if (sum_zero)
      res_d = {s2_nz_q, {(W-1){1'b0}}};
    else if (tiny)
      res_d = '0;
    else if (ovf)
      res_d = {s2_sign_q, EXP_MAX, {MAN_W{1'b0}}};
  end

  logic [W-1:0] res_q;

`ifdef FP_ADD_FLAGS_EN
  logic       grs_any;
  logic [2:0] flg_d, flg_q;

  assign grs_any = |norm[2:0];

  always_comb begin
    flg_d = 3'b000;
    if (s2_nan_q)
      flg_d = 3'b100;
    else if (s2_inf_q || sum_zero)
      flg_d = 3'b000;
    else if (tiny)
      flg_d = {2'b00, grs_any};
    else if (ovf)
      flg_d = 3'b011;
    else
      flg_d = {2'b00, grs_any};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flg_q <= 3'b000;
    else if (s3_adv && s2_v_q)
      flg_q <= flg_d;
  end

  assign flags = flg_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_v_q <= 1'b0;
      res_q  <= '0;
    end else if (s3_adv) begin
      s3_v_q <= s2_v_q;
      if (s2_v_q)
        res_q <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: vector table driven through a scoreboard queue, plus backpressure and reset sequences.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] float1 = '0;
  logic [31:0] float2 = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
`ifdef FP_ADD_FLAGS_EN
  logic [2:0]  flags;
`endif

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .float1    (float1),
    .float2    (float2),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef FP_ADD_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  localparam int NV = 20;
  vec_t vecs[NV];
  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Output monitor: pops the scoreboard on every completed transfer, checks hold while stalled
  logic [31:0] hold_res;
  bit          stalled = 0;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      stalled = 0;
    end else if (out_valid) begin
      if (stalled) check32("hold_result", result, hold_res);
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h required no output", result);
        end else begin
          mon_e = sb_q.pop_front();
          check32("result", result, mon_e.res);
`ifdef FP_ADD_FLAGS_EN
          check32("flags", {29'd0, flags}, {29'd0, mon_e.flg});
`endif
          if (mon_e.chk_lat) check_int("latency", cyc - mon_e.acc_cyc, 3);
        end
        stalled = 0;
      end else begin
        stalled  = 1;
        hold_res = result;
      end
    end
  end

  task automatic send(input vec_t v, input bit chk);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    float1   = v.a;
    float2   = v.b;
    sub      = v.s;
    #1;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready got 0 required 1");
      in_valid = 1'b0;
    end else begin
      e.res     = v.res;
      e.flg     = v.flg;
      e.acc_cyc = cyc;
      e.chk_lat = chk;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_int(name, sb_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h40400000, 32'hC0000000, 1'b0, 32'h3F800000, 3'b000};
    vecs[1]  = '{32'h40400000, 32'h40000000, 1'b0, 32'h40A00000, 3'b000};
    vecs[2]  = '{32'hC0400000, 32'hC0000000, 1'b0, 32'hC0A00000, 3'b000};
    vecs[3]  = '{32'hC0400000, 32'h40000000, 1'b0, 32'hBF800000, 3'b000};
    vecs[4]  = '{32'h40400000, 32'h40000000, 1'b1, 32'h3F800000, 3'b000};
    vecs[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001};
    vecs[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011};
    vecs[7]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100};
    vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
    vecs[9]  = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000};
    vecs[10] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
    vecs[11] = '{32'h3F800000, 32'h32800000, 1'b0, 32'h3F800000, 3'b001};
    vecs[12] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001};
    vecs[13] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100};
    vecs[14] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000};
    vecs[15] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};
    vecs[16] = '{32'h00800000, 32'h00800001, 1'b1, 32'h00000000, 3'b000};
    vecs[17] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000};
    vecs[18] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b001};
    vecs[19] = '{32'hBF800000, 32'h40000000, 1'b0, 32'h3F800000, 3'b000};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_int("reset_out_valid", int'(out_valid), 0);
    check32("reset_result", result, 32'h0);
    check_int("reset_in_ready", int'(in_ready), 1);

    // Full vector table streamed back-to-back; every result must arrive 3 cycles after acceptance
    for (int i = 0; i < NV; i++) send(vecs[i], 1'b1);
    idle();
    drain("table_drain");

    // Backpressure: four operands, output stalled 5 cycles once the first result shows
    fork
      begin
        for (int i = 1; i <= 4; i++) send(vecs[i], 1'b0);
        idle();
      end
      begin
        int  w;
        bit  saw_low;
        w = 0;
        saw_low = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!out_valid && w < 50);
        if (!out_valid) begin
          checks++;
          failures++;
          $display("FAIL bp_wait: out_valid got 0 required 1");
        end
        out_ready = 1'b0;
        repeat (5) begin
          #1;
          if (!in_ready) saw_low = 1;
          @(negedge clk);
        end
        out_ready = 1'b1;
        check_int("bp_in_ready_dropped", int'(saw_low), 1);
      end
    join
    drain("bp_drain");

    // Reset with two operands in flight: nothing may emerge for them
    send(vecs[0], 1'b0);
    send(vecs[1], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_int("rst_flush_out_valid", int'(out_valid), 0);
      check32("rst_flush_result", result, 32'h0);
      @(negedge clk);
    end
    send(vecs[0], 1'b1);
    idle();
    drain("post_reset_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
